// File: rtl/pxi_pkg.sv
// pxi_pkg: shared definitions for the PXI register-write sequencer.
//   wr_state_e      : frame sequencer states
//   HDR_OPCODE      : upper nibble that marks a header word
//   DEF_TIMEOUT_CYC : default inter-word timeout in clk cycles
package pxi_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGetLo = 2'd1,
        StGetHi = 2'd2,
        StIssue = 2'd3
    } wr_state_e;

    localparam logic [3:0]  HDR_OPCODE      = 4'hA;
    localparam int unsigned DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/pxi_strobe_sync.sv
// pxi_strobe_sync: brings the asynchronous PXI write strobe into the clk domain
// and turns each rising edge into a single-cycle pulse.
//   clk       : system clock
//   rst_n     : synchronous active-low reset, clears all three flops
//   async_in  : asynchronous strobe
//   pulse_out : one-cycle pulse per rising edge of async_in
module pxi_strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse_out
);

    // [0],[1] form the two-flop synchroniser, [2] holds the previous value.
    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], async_in};
        end
    end

    assign pulse_out = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pxi_wr_seq.sv
// pxi_wr_seq: assembles three PXI words (header, data low, data high) into a
// single register write and presents it on a valid/ready interface.
//   clk, rst_n         : clock, synchronous active-low reset
//   pxi_word           : word from the upstream write latch
//   pxi_strobe         : asynchronous write strobe, rising edge = new word
//   wr_valid/wr_ready  : write handshake
//   wr_addr, wr_data   : write address and data, held between frames
//   err_hdr            : pulse, first word of a frame lacked the header opcode
//   err_ovr            : pulse, word arrived while a write was still pending
//   err_tmo            : pulse, inter-word timeout (only with PXI_WR_TIMEOUT_EN)
//   busy               : sequencer not idle
// Build option: define PXI_WR_TIMEOUT_EN to add the inter-word timeout counter.
module pxi_wr_seq
    import pxi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       pxi_word,
    input  logic              pxi_strobe,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              err_hdr,
    output logic              err_ovr,
    output logic              err_tmo,
    output logic              busy
);

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              err_hdr_q, err_hdr_d;
    logic              err_ovr_q, err_ovr_d;
    logic              ev;
    logic              tmo_hit;

    pxi_strobe_sync u_strobe_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .async_in  (pxi_strobe),
        .pulse_out (ev)
    );

`ifdef PXI_WR_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            err_tmo_q;
    logic            in_get;

    assign in_get  = (state_q == StGetLo) || (state_q == StGetHi);
    // A word arriving on the expiry cycle wins over the timeout.
    assign tmo_hit = in_get && !ev && (tmo_cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_comb begin
        tmo_cnt_d = '0;
        if (in_get && !ev && !tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_tmo_q <= tmo_hit;
        end
    end

    assign err_tmo = err_tmo_q;
`else
    assign tmo_hit = 1'b0;
    assign err_tmo = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        err_hdr_d = 1'b0;
        err_ovr_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ev) begin
                    if (pxi_word[15:12] == HDR_OPCODE) begin
                        addr_d  = ADDR_W'(pxi_word);
                        state_d = StGetLo;
                    end else begin
                        err_hdr_d = 1'b1;
                    end
                end
            end
            StGetLo: begin
                if (ev) begin
                    data_d[15:0] = pxi_word;
                    state_d      = StGetHi;
                end else if (tmo_hit) begin
                    state_d = StIdle;
                end
            end
            StGetHi: begin
                if (ev) begin
                    data_d[31:16] = pxi_word;
                    state_d       = StIssue;
                end else if (tmo_hit) begin
                    state_d = StIdle;
                end
            end
            StIssue: begin
                // A word here is always dropped, even if the handshake
                // completes in the same cycle; it never opens a new frame.
                if (ev) begin
                    err_ovr_d = 1'b1;
                end
                if (wr_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            data_q    <= '0;
            err_hdr_q <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            err_hdr_q <= err_hdr_d;
            err_ovr_q <= err_ovr_d;
        end
    end

    assign wr_valid = (state_q == StIssue);
    assign busy     = (state_q != StIdle);
    assign wr_addr  = addr_q;
    assign wr_data  = data_q;
    assign err_hdr  = err_hdr_q;
    assign err_ovr  = err_ovr_q;

endmodule
